// File: rtl/otter_mem_pkg.sv
// Shared types and helpers for the OTTER data-memory responder.
package otter_mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_t;

    // Half accesses need an even address, words a 4-byte aligned one.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (size == MEM_HALF) begin
            bad = addr_lo[0];
        end else if (size == MEM_WORD) begin
            bad = (addr_lo != 2'b00);
        end
        return bad;
    endfunction

endpackage

// File: rtl/otter_load_align.sv
// Extracts the addressed byte/half from a memory word and sign/zero-extends it.
module otter_load_align
    import otter_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;

    always_comb begin
        byte_shift = word >> {addr_lo, 3'b000};
        half_shift = word >> {addr_lo[1], 4'b0000};
        result     = 32'd0;
        case (size)
            MEM_BYTE: result = {{24{~is_unsigned & byte_shift[7]}}, byte_shift[7:0]};
            MEM_HALF: result = {{16{~is_unsigned & half_shift[15]}}, half_shift[15:0]};
            MEM_WORD: result = word;
            default:  result = 32'd0;
        endcase
    end

endmodule

// File: rtl/otter_dmem_responder.sv
// Data-memory responder for the OTTER MEM stage: one request at a time,
// fixed latency, byte-enabled word array with registered read.
module otter_dmem_responder
    import otter_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int LATENCY    = 2,
    parameter     INIT_FILE  = ""
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ_VALID,
    input  logic        REQ_WE,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    input  logic [1:0]  REQ_SIZE,
    input  logic        REQ_UNSIGNED,
    output logic        REQ_READY,
    output logic        RSP_VALID,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic        BUSY
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int AW    = ADDR_WIDTH + 2;

    logic [31:0] mem [DEPTH];

    dmem_state_t state_reg;
    logic [3:0]  cnt_reg;
    logic        ready_reg;
    logic        rsp_valid_reg;
    logic        busy_reg;
    logic        we_reg;
    logic [AW-1:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [1:0]  size_reg;
    logic        uns_reg;
    logic        err_reg;
    logic [31:0] rd_word_reg;

    logic          req_err;
    logic          enter_resp;
    logic          from_req;
    logic          cur_we;
    logic          cur_err;
    logic [AW-1:0] cur_addr;
    logic [31:0]   cur_wdata;
    logic [1:0]    cur_size;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [3:0]    byte_en;
    logic [31:0]   wlane;
    logic [31:0]   load_result;

    assign req_err = (REQ_SIZE == 2'b11)
                   | misaligned(REQ_SIZE, REQ_ADDR[1:0])
                   | ((REQ_ADDR >> AW) != 32'd0);

    // With LATENCY=1 the accept edge is also the commit edge, so the
    // access must be taken straight from the request inputs.
    assign from_req   = (state_reg == IDLE);
    assign enter_resp = !RESET &&
                        (((LATENCY == 1) && from_req && REQ_VALID) ||
                         ((state_reg == WAIT) && (cnt_reg == 4'd0)));

    assign cur_we    = from_req ? REQ_WE            : we_reg;
    assign cur_err   = from_req ? req_err           : err_reg;
    assign cur_addr  = from_req ? REQ_ADDR[AW-1:0]  : addr_reg;
    assign cur_wdata = from_req ? REQ_WDATA         : wdata_reg;
    assign cur_size  = from_req ? REQ_SIZE          : size_reg;
    assign word_idx  = cur_addr[AW-1:2];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign byte_en[gi] = cur_we && !cur_err &&
                                 ((cur_size == MEM_WORD) ||
                                  ((cur_size == MEM_HALF) && (cur_addr[1] == LANE[1])) ||
                                  ((cur_size == MEM_BYTE) && (cur_addr[1:0] == LANE)));
            assign wlane[gi*8 +: 8] = (cur_size == MEM_BYTE) ? cur_wdata[7:0] :
                                      (cur_size == MEM_HALF) ? cur_wdata[8*(gi%2) +: 8] :
                                                               cur_wdata[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (enter_resp) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][i*8 +: 8] <= wlane[i*8 +: 8];
                end
            end
            rd_word_reg <= mem[word_idx];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            ready_reg     <= 1'b1;
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= 32'd0;
            size_reg      <= 2'b00;
            uns_reg       <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (REQ_VALID) begin
                        we_reg    <= REQ_WE;
                        addr_reg  <= REQ_ADDR[AW-1:0];
                        wdata_reg <= REQ_WDATA;
                        size_reg  <= REQ_SIZE;
                        uns_reg   <= REQ_UNSIGNED;
                        err_reg   <= req_err;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                        if (LATENCY == 1) begin
                            state_reg     <= RESP;
                            rsp_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= WAIT;
                            cnt_reg   <= 4'(LATENCY - 2);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    state_reg     <= IDLE;
                    rsp_valid_reg <= 1'b0;
                    ready_reg     <= 1'b1;
                    busy_reg      <= 1'b0;
                end
                default: begin
                    state_reg     <= IDLE;
                    rsp_valid_reg <= 1'b0;
                    ready_reg     <= 1'b1;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    otter_load_align u_align (
        .word        (rd_word_reg),
        .addr_lo     (addr_reg[1:0]),
        .size        (size_reg),
        .is_unsigned (uns_reg),
        .result      (load_result)
    );

    assign REQ_READY = ready_reg;
    assign RSP_VALID = rsp_valid_reg;
    assign BUSY      = busy_reg;
    assign RSP_ERR   = rsp_valid_reg & err_reg;
    assign RSP_RDATA = (rsp_valid_reg && !err_reg && !we_reg) ? load_result : 32'd0;

endmodule

// File: tb/tb_otter_dmem_responder.sv
// Directed bench: instance 0 uses LATENCY=2, instances 1/2 use LATENCY=1/3.
module tb_otter_dmem_responder;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_uns;
    logic        vld   [3];
    logic        rdy   [3];
    logic        rspv  [3];
    logic        rerr  [3];
    logic        bsy   [3];
    logic [31:0] rdata [3];

    int n_vec = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        otter_dmem_responder #(
            .ADDR_WIDTH (14),
            .LATENCY    ((gi == 0) ? 2 : ((gi == 1) ? 1 : 3)),
            .INIT_FILE  ("")
        ) dut (
            .CLK          (CLK),
            .RESET        (RESET),
            .REQ_VALID    (vld[gi]),
            .REQ_WE       (req_we),
            .REQ_ADDR     (req_addr),
            .REQ_WDATA    (req_wdata),
            .REQ_SIZE     (req_size),
            .REQ_UNSIGNED (req_uns),
            .REQ_READY    (rdy[gi]),
            .RSP_VALID    (rspv[gi]),
            .RSP_RDATA    (rdata[gi]),
            .RSP_ERR      (rerr[gi]),
            .BUSY         (bsy[gi])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One request on the LATENCY=2 instance, checked for latency, data, error and pulse width.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        @(negedge CLK);
        req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_uns = uns;
        vld[0] = 1'b1;
        n = 0;
        while (!rdy[0] && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check($sformatf("%s.ready", tag), 32'(rdy[0]), 32'd1);
        @(posedge CLK);
        #1 vld[0] = 1'b0;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!rspv[0] && n < 20);
        check($sformatf("%s.latency", tag), 32'(n), 32'd2);
        check($sformatf("%s.rdata", tag), rdata[0], exp_rdata);
        check($sformatf("%s.err", tag), 32'(rerr[0]), 32'(exp_err));
        $display("txn %s we=%0d addr=%08h wdata=%08h size=%0d uns=%0d -> rdata=%08h err=%0d lat=%0d",
                 tag, we, addr, wdata, size, uns, rdata[0], rerr[0], n);
        @(negedge CLK);
        check($sformatf("%s.pulse", tag), 32'(rspv[0]), 32'd0);
        check($sformatf("%s.rdata_idle", tag), rdata[0], 32'd0);
        check($sformatf("%s.err_idle", tag), 32'(rerr[0]), 32'd0);
    endtask

    // REQ_VALID held high for four loads on instance k with latency lat.
    task automatic stream(input int k, input int lat);
        int na;
        int last_acc;
        int acc_t [4];
        na = 0;
        last_acc = -100;
        @(negedge CLK);
        req_we = 1'b0; req_addr = 32'h100; req_wdata = 32'd0; req_size = 2'b10; req_uns = 1'b0;
        vld[k] = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            check($sformatf("stream%0d.busy@%0d", lat, cyc), 32'(bsy[k]),
                  32'((cyc > last_acc) && (cyc <= last_acc + lat)));
            check($sformatf("stream%0d.rspv@%0d", lat, cyc), 32'(rspv[k]),
                  32'(cyc == last_acc + lat));
            if (vld[k] && rdy[k] && na < 4) begin
                acc_t[na] = cyc;
                na++;
                last_acc = cyc;
                $display("txn stream lat=%0d accept #%0d at cycle %0d", lat, na, cyc);
            end
            if (na == 4 && vld[k]) begin
                @(posedge CLK);
                #1 vld[k] = 1'b0;
            end
            @(negedge CLK);
        end
        check($sformatf("stream%0d.accepts", lat), 32'(na), 32'd4);
        for (int i = 1; i < 4; i++) begin
            if (i < na) begin
                check($sformatf("stream%0d.spacing%0d", lat, i), 32'(acc_t[i] - acc_t[i-1]),
                      32'(lat + 1));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) vld[i] = 1'b0;
        req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_size = 2'b00; req_uns = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("reset.ready", 32'(rdy[0]), 32'd1);
        check("reset.rspv",  32'(rspv[0]), 32'd0);
        check("reset.rdata", rdata[0], 32'd0);
        check("reset.err",   32'(rerr[0]), 32'd0);
        check("reset.busy",  32'(bsy[0]), 32'd0);

        do_req("sw100",   1'b1, 32'h100, 32'hDEADBEEF, 2'b10, 1'b0, 32'h00000000, 1'b0);
        do_req("lw100",   1'b0, 32'h100, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
        do_req("sb101",   1'b1, 32'h101, 32'h000000A5, 2'b00, 1'b0, 32'h00000000, 1'b0);
        do_req("lb101",   1'b0, 32'h101, 32'h0,        2'b00, 1'b0, 32'hFFFFFFA5, 1'b0);
        do_req("lbu101",  1'b0, 32'h101, 32'h0,        2'b00, 1'b1, 32'h000000A5, 1'b0);
        do_req("lw100b",  1'b0, 32'h100, 32'h0,        2'b10, 1'b0, 32'hDEADA5EF, 1'b0);
        do_req("lb103",   1'b0, 32'h103, 32'h0,        2'b00, 1'b0, 32'hFFFFFFDE, 1'b0);
        do_req("lbu100",  1'b0, 32'h100, 32'h0,        2'b00, 1'b1, 32'h000000EF, 1'b0);
        do_req("lh102",   1'b0, 32'h102, 32'h0,        2'b01, 1'b0, 32'hFFFFDEAD, 1'b0);
        do_req("lhu102",  1'b0, 32'h102, 32'h0,        2'b01, 1'b1, 32'h0000DEAD, 1'b0);
        do_req("lh101",   1'b0, 32'h101, 32'h0,        2'b01, 1'b0, 32'h00000000, 1'b1);
        do_req("sw102",   1'b1, 32'h102, 32'h12345678, 2'b10, 1'b0, 32'h00000000, 1'b1);
        do_req("lw10000", 1'b0, 32'h00010000, 32'h0,   2'b10, 1'b0, 32'h00000000, 1'b1);
        do_req("lsz11",   1'b0, 32'h100, 32'h0,        2'b11, 1'b0, 32'h00000000, 1'b1);
        do_req("lw100c",  1'b0, 32'h100, 32'h0,        2'b10, 1'b0, 32'hDEADA5EF, 1'b0);
        do_req("sw104",   1'b1, 32'h104, 32'h00000000, 2'b10, 1'b0, 32'h00000000, 1'b0);
        do_req("sh106",   1'b1, 32'h106, 32'hFFFF7BCD, 2'b01, 1'b0, 32'h00000000, 1'b0);
        do_req("lw104",   1'b0, 32'h104, 32'h0,        2'b10, 1'b0, 32'h7BCD0000, 1'b0);
        do_req("lh106",   1'b0, 32'h106, 32'h0,        2'b01, 1'b0, 32'h00007BCD, 1'b0);

        // Reset lands in WAIT of a store; the store must not commit.
        do_req("sw200a",  1'b1, 32'h200, 32'h11223344, 2'b10, 1'b0, 32'h00000000, 1'b0);
        @(negedge CLK);
        req_we = 1'b1; req_addr = 32'h200; req_wdata = 32'h00000055; req_size = 2'b10; req_uns = 1'b0;
        vld[0] = 1'b1;
        check("rst.idle_before", 32'(rdy[0]), 32'd1);
        @(posedge CLK);
        #1 vld[0] = 1'b0;
        @(negedge CLK);
        check("rst.wait_busy", 32'(bsy[0]), 32'd1);
        check("rst.wait_rspv", 32'(rspv[0]), 32'd0);
        RESET = 1'b1;
        @(negedge CLK);
        check("rst.in_rspv", 32'(rspv[0]), 32'd0);
        RESET = 1'b0;
        @(negedge CLK);
        check("rst.after_ready", 32'(rdy[0]), 32'd1);
        check("rst.after_rspv",  32'(rspv[0]), 32'd0);
        check("rst.after_busy",  32'(bsy[0]), 32'd0);
        $display("txn reset during WAIT of sw 0x55 @0x200");
        do_req("lw200",   1'b0, 32'h200, 32'h0,        2'b10, 1'b0, 32'h11223344, 1'b0);

        stream(1, 1);
        stream(2, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/otter_dmem_responder.md
Name: otter_dmem_responder

Overview:
- Data-memory responder for the OTTER pipeline's MEM stage; it is the memory side of the CPU's load/store access.
- Accepts one request at a time over a valid/ready handshake.
- Performs byte/half/word accesses on an internal word-organised array after a fixed, parameterised latency.
- Returns aligned, sign- or zero-extended read data with an error flag; the CPU holds stall_mem from request until RSP_VALID.

Parameters:
- ADDR_WIDTH, 14, word-address bits; array is 2**ADDR_WIDTH 32-bit words.
- LATENCY, 2, cycles from accept edge to RSP_VALID cycle; legal range 1..15.
- INIT_FILE, "", optional $readmemh image; empty means the array is not initialised.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  request present; requester holds all REQ_* stable until accepted.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_ADDR  in  32  byte address.
- REQ_WDATA  in  32  store data, right-justified.
- REQ_SIZE  in  2  00 byte, 01 half, 10 word, 11 illegal.
- REQ_UNSIGNED  in  1  load zero-extends when 1, sign-extends when 0 (funct3[2]).
- REQ_READY  out  1  responder can accept.
- RSP_VALID  out  1  one-cycle response pulse.
- RSP_RDATA  out  32  extended load data; 0 for stores and errors.
- RSP_ERR  out  1  misaligned, illegal size or out-of-range; qualified by RSP_VALID.
- BUSY  out  1  request in flight (state != IDLE).

Behaviour:
- Reset (synchronous, any state):
  - state to IDLE; REQ_READY=1 from the first cycle after reset; RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, BUSY=0.
  - A pending request is dropped with no response. Its write is not performed unless already committed.
  - Array contents are not cleared.
- FSM states IDLE, WAIT, RESP:
  - IDLE: REQ_READY=1. Accept on posedge with REQ_VALID=1. Latch we, addr, wdata, size, unsigned and the error check. If LATENCY=1 go to RESP, else go to WAIT with counter=LATENCY-2.
  - WAIT: REQ_READY=0. At counter==0 go to RESP, otherwise decrement.
  - RESP: RSP_VALID=1 for exactly one cycle, REQ_READY=0, then IDLE.
- Timing:
  - Accept at edge t gives RSP_VALID high in cycle t+LATENCY.
  - Maximum throughput is one request per LATENCY+1 cycles.
  - REQ_VALID outside IDLE is ignored and not queued.
- Commit: the array write and read sample occur on the edge entering RESP. RSP_RDATA and RSP_ERR are registered and valid only while RSP_VALID=1; they hold 0 otherwise.
- Error conditions:
  - size 11.
  - half with addr[0]=1.
  - word with addr[1:0]!=0.
  - addr[31:ADDR_WIDTH+2]!=0.
- Error response: no write, RSP_RDATA=0, RSP_ERR=1, same latency as a normal access.
- Store lanes: byte writes lane addr[1:0]; half writes lanes {addr[1],0} and {addr[1],1}; word writes all four. Other bytes are preserved, using per-byte write enables.
- Load:
  - byte = word >> (8*addr[1:0]) [7:0]; half = word >> (16*addr[1]) [15:0].
  - Extend by REQ_UNSIGNED; a word load ignores REQ_UNSIGNED.
- Array is inferable as block RAM with byte enables. Word index is addr[ADDR_WIDTH+1:2].

Decomposition:
- Package otter_mem_pkg:
  - mem_size_t enum (MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10).
  - dmem_state_t enum (IDLE, WAIT, RESP).
  - Function misaligned(size, addr[1:0]).
- One sub-module, otter_load_align: combinational lane extraction plus sign/zero extension (word, addr[1:0], size, unsigned → 32-bit result). Byte-enable generation stays in the top.

Test Plan:
- Reset, SW 0xDEADBEEF @0x100, then LW @0x100 (LATENCY=2) → each RSP_VALID exactly 2 cycles after accept; LW RSP_RDATA=0xDEADBEEF, RSP_ERR=0; SW RSP_RDATA=0.
- SB 0x000000A5 @0x101, then LB/LBU/LW @0x101/0x101/0x100 → 0xFFFFFFA5 / 0x000000A5 / 0xDEADA5EF.
- LH @0x102 → 0xFFFFDEAD; LHU @0x102 → 0x0000DEAD; LH @0x101 → RSP_ERR=1, RSP_RDATA=0.
- SW 0x12345678 @0x102 (misaligned) and LW @0x00010000 (ADDR_WIDTH=14, out of range) → both RSP_ERR=1 after LATENCY; LW @0x100 still 0xDEADA5EF.
- Assert RESET during WAIT of SW 0x55 @0x200 → no RSP_VALID; REQ_READY=1 the cycle after RESET drops; LW @0x200 returns the prior contents.
- REQ_VALID held high for 4 loads with LATENCY=1 and LATENCY=3 → accepts spaced 2 and 4 cycles apart; RSP_VALID pulses exactly one cycle each; BUSY=1 between accept and RESP.
